// File: rtl/alarm_clock_fsm.sv
// alarm_clock_fsm: sequencing controller for the four-digit alarm-clock LCD datapath.
// Decodes keypad / alarm / time buttons into datapath strobes and abandons a
// partial key entry after TIMEOUT_SECS one_second pulses of keypad inactivity.
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset
//   one_second    single-cycle pulse once per second
//   key           keypad code, NOKEY when idle
//   alarm_button  level, show or set the alarm time
//   time_button   level, load entered time as current time
//   show_a        display selects the alarm time
//   show_new_time display selects the key-entry digits
//   shift         one-cycle strobe, shift key into key register
//   load_new_a    one-cycle strobe, load key register into alarm register
//   load_new_c    one-cycle strobe, load key register into current-time counter
module alarm_clock_fsm #(
  parameter int unsigned TIMEOUT_SECS = 10,
  parameter logic [3:0]  NOKEY        = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_SECS - 1);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             timeout_c;
  logic             key_pressed_c;

  logic show_a_nxt, show_new_time_nxt, shift_nxt, load_new_a_nxt, load_new_c_nxt;

  assign key_pressed_c = (key != NOKEY);
  assign timeout_c     = (count == CNT_MAX) && one_second;

  // State, counter and output registers; outputs mirror the decode of the
  // state being entered, so they always reflect the current state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= SHOW_TIME;
      count         <= '0;
      show_a        <= 1'b0;
      show_new_time <= 1'b0;
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      show_a        <= show_a_nxt;
      show_new_time <= show_new_time_nxt;
      shift         <= shift_nxt;
      load_new_a    <= load_new_a_nxt;
      load_new_c    <= load_new_c_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)       state_nxt = SHOW_ALARM;
        else if (key_pressed_c) state_nxt = KEY_STORED;
      end
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed_c)     state_nxt = KEY_ENTRY;
        else if (timeout_c)     state_nxt = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)       state_nxt = SET_ALARM_TIME;
        else if (time_button)   state_nxt = SET_CURRENT_TIME;
        else if (key_pressed_c) state_nxt = KEY_STORED;
        else if (timeout_c)     state_nxt = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button)      state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME:           state_nxt = SHOW_TIME;
      SET_CURRENT_TIME:         state_nxt = SHOW_TIME;
      default:                  state_nxt = SHOW_TIME;
    endcase
  end

  // Inactivity counter: runs only while waiting for keys, saturates at CNT_MAX.
  always_comb begin
    count_nxt = '0;
    if (state == KEY_WAITED || state == KEY_ENTRY) begin
      count_nxt = count;
      if (one_second && (count != CNT_MAX)) count_nxt = count + CNT_W'(1);
    end
  end

  // Output decode of the next state.
  always_comb begin
    show_a_nxt        = 1'b0;
    show_new_time_nxt = 1'b0;
    shift_nxt         = 1'b0;
    load_new_a_nxt    = 1'b0;
    load_new_c_nxt    = 1'b0;
    case (state_nxt)
      SHOW_ALARM:       show_a_nxt        = 1'b1;
      KEY_STORED:       shift_nxt         = 1'b1;
      KEY_WAITED,
      KEY_ENTRY:        show_new_time_nxt = 1'b1;
      SET_ALARM_TIME:   load_new_a_nxt    = 1'b1;
      SET_CURRENT_TIME: load_new_c_nxt    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Self-checking bench for alarm_clock_fsm: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a model.
module tb_alarm_clock_fsm;

  localparam int unsigned T     = 10;
  localparam logic [3:0]  NOKEY = 4'd10;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_a, show_new_time, shift, load_new_a, load_new_c;

  alarm_clock_fsm #(.TIMEOUT_SECS(T), .NOKEY(NOKEY)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key(key),
    .alarm_button(alarm_button), .time_button(time_button),
    .show_a(show_a), .show_new_time(show_new_time), .shift(shift),
    .load_new_a(load_new_a), .load_new_c(load_new_c)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [4:0] dut_vec;
  assign dut_vec = {show_a, show_new_time, shift, load_new_a, load_new_c};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: what the display is doing, plus the number of second
  // pulses seen since the last digit was taken (unbounded integer).
  localparam int M_IDLE = 0, M_ALARM = 1, M_SHIFT = 2, M_HELD = 3,
                 M_ENTRY = 4, M_LOAD_A = 5, M_LOAD_C = 6;
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_after;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_secs = 0;
    end else begin
      m_after = m_secs + (one_second ? 1 : 0);
      case (m_mode)
        M_IDLE:   if (alarm_button) m_mode = M_ALARM;
                  else if (key != NOKEY) m_mode = M_SHIFT;
        M_ALARM:  if (!alarm_button) m_mode = M_IDLE;
        M_SHIFT:  begin m_mode = M_HELD; m_secs = 0; end
        M_HELD: begin
          m_secs = m_after;
          if (key == NOKEY) m_mode = M_ENTRY;
          else if (m_after >= T) m_mode = M_IDLE;
        end
        M_ENTRY: begin
          m_secs = m_after;
          if (alarm_button) m_mode = M_LOAD_A;
          else if (time_button) m_mode = M_LOAD_C;
          else if (key != NOKEY) m_mode = M_SHIFT;
          else if (m_after >= T) m_mode = M_IDLE;
        end
        default:  m_mode = M_IDLE;
      endcase
    end
  end

  function automatic logic [4:0] model_vec(input int mode);
    case (mode)
      M_ALARM:         return 5'b10000;
      M_HELD, M_ENTRY: return 5'b01000;
      M_SHIFT:         return 5'b00100;
      M_LOAD_A:        return 5'b00010;
      M_LOAD_C:        return 5'b00001;
      default:         return 5'b00000;
    endcase
  endfunction

  // Compare process: every falling edge, DUT outputs vs model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("outputs_vs_model", 32'(dut_vec), 32'(model_vec(m_mode)));
      chk("outputs_exclusive", 32'($countones(dut_vec) <= 1), 32'd1);
    end
  end

  int n_shift, n_show_a, n_load_a, n_load_c;

  task automatic clr();
    n_shift = 0; n_show_a = 0; n_load_a = 0; n_load_c = 0;
  endtask

  // One clock with the given inputs; tallies the outputs seen after the edge.
  task automatic cyc(input logic [3:0] k, input logic a, input logic t, input logic s);
    key = k; alarm_button = a; time_button = t; one_second = s;
    @(posedge clock);
    #1;
    n_shift  += int'(shift);
    n_show_a += int'(show_a);
    n_load_a += int'(load_new_a);
    n_load_c += int'(load_new_c);
  endtask

  task automatic digit(input logic [3:0] d);
    cyc(d, 1'b0, 1'b0, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
  endtask

  int quiet;

  initial begin
    reset = 1'b1; key = NOKEY; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
    #2 reset = 1'b0;
    check_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk("reset_outputs", 32'(dut_vec), 32'd0);
    reset = 1'b1;
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    chk("idle_after_reset", 32'(dut_vec), 32'd0);

    // Held key: one shift only.
    clr();
    repeat (5) cyc(4'd3, 1'b0, 1'b0, 1'b0);
    chk("held_key_show_new", 32'(show_new_time), 32'd1);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    chk("held_key_shifts", 32'(n_shift), 32'd1);
    chk("entry_show_new", 32'(show_new_time), 32'd1);

    // Reset mid-entry clears outputs immediately.
    reset = 1'b0;
    #1 chk("reset_mid_entry", 32'(dut_vec), 32'd0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    chk("idle_after_mid_reset", 32'(dut_vec), 32'd0);

    // Four digits then time_button.
    clr();
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd0);
    cyc(NOKEY, 1'b0, 1'b1, 1'b0);
    chk("load_c_strobe", 32'(load_new_c), 32'd1);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    chk("four_digit_shifts", 32'(n_shift), 32'd4);
    chk("four_digit_load_c", 32'(n_load_c), 32'd1);
    chk("after_load_c_idle", 32'(dut_vec), 32'd0);

    // Alarm set with both buttons: alarm wins.
    clr();
    digit(4'd0); digit(4'd7);
    cyc(NOKEY, 1'b1, 1'b1, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    chk("both_buttons_load_a", 32'(n_load_a), 32'd1);
    chk("both_buttons_load_c", 32'(n_load_c), 32'd0);

    // Show alarm held 20 cycles, key ignored.
    clr();
    repeat (20) cyc(4'd5, 1'b1, 1'b0, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    chk("show_a_cycles", 32'(n_show_a), 32'd20);
    chk("show_a_no_shift", 32'(n_shift), 32'd0);
    chk("show_a_released", 32'(dut_vec), 32'd0);

    // Timeout after the 10th pulse.
    digit(4'd8);
    repeat (T - 1) cyc(NOKEY, 1'b0, 1'b0, 1'b1);
    chk("nine_pulses_entry", 32'(show_new_time), 32'd1);
    cyc(NOKEY, 1'b0, 1'b0, 1'b1);
    chk("tenth_pulse_timeout", 32'(show_new_time), 32'd0);

    // Key coinciding with the 10th pulse wins; counter restarts.
    digit(4'd8);
    repeat (T - 1) cyc(NOKEY, 1'b0, 1'b0, 1'b1);
    cyc(4'd4, 1'b0, 1'b0, 1'b1);
    chk("key_beats_timeout", 32'(shift), 32'd1);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    cyc(NOKEY, 1'b0, 1'b0, 1'b0);
    repeat (T - 1) cyc(NOKEY, 1'b0, 1'b0, 1'b1);
    chk("restart_nine_pulses", 32'(show_new_time), 32'd1);
    cyc(NOKEY, 1'b0, 1'b0, 1'b1);
    chk("restart_timeout", 32'(show_new_time), 32'd0);

    // Randomized traffic, alternating busy and quiet segments.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] k;
      if (i % 60 == 0) quiet = int'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < (quiet != 0 ? 3 : 40)) k = 4'($urandom_range(0, 15));
      else k = NOKEY;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        cyc(k, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
      end else begin
        cyc(k, $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 2) == 0);
      end
    end

    @(negedge clock);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
